// File: rtl/execution_dispatch_unit_pkg.sv
// Shared definitions for the execution dispatch unit: controller states and
// the position of the branch-class flag within the opcode.
package execution_dispatch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ALU,
    ST_WRITEBACK,
    ST_FLUSH
  } state_e;

  // Branch-class flag sits this many bits below the opcode MSB.
  localparam int BRANCH_BIT_OFS = 0;

endpackage

// File: rtl/dispatch_fifo.sv
// DEPTH x W circular FIFO with occupancy count and synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [W-1:0]                 i_data,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full, w_do_push, w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/execution_dispatch_unit.sv
// Queues decoded instructions, issues them one at a time to the ALU with
// last-write forwarding, then writes back to data RAM or resolves a branch.
module execution_dispatch_unit
  import execution_dispatch_unit_pkg::*;
#(
  parameter int LANES           = 3,
  parameter int WIDTH           = 32,
  parameter int DATA_ADDR_WIDTH = 10,
  parameter int OP_WIDTH        = 6,
  parameter int DEPTH           = 4
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        iValid,
  output logic                        oReady,
  input  logic [OP_WIDTH-1:0]         iOperation,
  input  logic [DATA_ADDR_WIDTH-1:0]  iDestination,
  input  logic [DATA_ADDR_WIDTH-1:0]  iSrcAddr0,
  input  logic [DATA_ADDR_WIDTH-1:0]  iSrcAddr1,
  input  logic [LANES*WIDTH-1:0]      iSource0,
  input  logic [LANES*WIDTH-1:0]      iSource1,
  output logic                        oTriggerALU,
  output logic [OP_WIDTH-1:0]         oALUOperation,
  output logic [LANES*WIDTH-1:0]      oALUChannelA,
  output logic [LANES*WIDTH-1:0]      oALUChannelB,
  input  logic [LANES*WIDTH-1:0]      iALUResult,
  input  logic                        iALUOutputReady,
  input  logic                        iBranchTaken,
  output logic                        oRAMWriteEnable,
  output logic [DATA_ADDR_WIDTH-1:0]  oRAMWriteAddress,
  output logic [LANES*WIDTH-1:0]      oRAMBus,
  output logic                        oJumpFlag,
  output logic [DATA_ADDR_WIDTH-1:0]  oJumpIp,
  output logic [DATA_ADDR_WIDTH-1:0]  oLastDestination,
  output logic                        oBusy
);
  localparam int DW = LANES*WIDTH;
  localparam int AW = DATA_ADDR_WIDTH;
  localparam int EW = OP_WIDTH + 3*AW + 2*DW;
  localparam int CW = $clog2(DEPTH+1);

  state_e            r_state, w_next;
  logic              w_push, w_pop, w_clear, w_empty, w_is_branch;
  logic [CW-1:0]     w_count;
  logic [EW-1:0]     w_head;
  logic [OP_WIDTH-1:0] w_h_op;
  logic [AW-1:0]     w_h_dest, w_h_s0a, w_h_s1a;
  logic [DW-1:0]     w_h_s0, w_h_s1;

  logic              r_trig, r_fwd_vld;
  logic [OP_WIDTH-1:0] r_op;
  logic [AW-1:0]     r_dest, r_last_dest;
  logic [DW-1:0]     r_cha, r_chb, r_result, r_fwd_data;

  assign w_push = iValid && oReady;

  dispatch_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk     (Clock),
    .rst_n   (Reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({iOperation, iDestination, iSrcAddr0, iSrcAddr1, iSource0, iSource1}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign {w_h_op, w_h_dest, w_h_s0a, w_h_s1a, w_h_s0, w_h_s1} = w_head;
  assign w_is_branch = r_op[OP_WIDTH-1-BRANCH_BIT_OFS];

  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      ST_IDLE:      if (!w_empty) w_next = ST_ISSUE;
      ST_ISSUE: begin
        w_pop  = 1'b1;
        w_next = ST_WAIT_ALU;
      end
      ST_WAIT_ALU: begin
        if (iALUOutputReady) begin
          if (!w_is_branch)     w_next = ST_WRITEBACK;
          else if (iBranchTaken) w_next = ST_FLUSH;
          else                  w_next = w_empty ? ST_IDLE : ST_ISSUE;
        end
      end
      ST_WRITEBACK: w_next = w_empty ? ST_IDLE : ST_ISSUE;
      ST_FLUSH: begin
        w_clear = 1'b1;
        w_next  = ST_IDLE;
      end
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_trig      <= 1'b0;
      r_op        <= '0;
      r_dest      <= '0;
      r_cha       <= '0;
      r_chb       <= '0;
      r_result    <= '0;
      r_last_dest <= '0;
      r_fwd_data  <= '0;
      r_fwd_vld   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_trig  <= (r_state == ST_ISSUE);
      if (r_state == ST_ISSUE) begin
        r_op   <= w_h_op;
        r_dest <= w_h_dest;
        // A write landing in the same edge as this issue is already visible here.
        r_cha  <= (r_fwd_vld && w_h_s0a == r_last_dest) ? r_fwd_data : w_h_s0;
        r_chb  <= (r_fwd_vld && w_h_s1a == r_last_dest) ? r_fwd_data : w_h_s1;
      end
      if (r_state == ST_WAIT_ALU && iALUOutputReady) r_result <= iALUResult;
      if (r_state == ST_WRITEBACK) begin
        r_last_dest <= r_dest;
        r_fwd_data  <= r_result;
        r_fwd_vld   <= 1'b1;
      end
    end
  end

  assign oReady           = (w_count != CW'(DEPTH)) && (r_state != ST_FLUSH);
  assign oBusy            = !w_empty || (r_state != ST_IDLE);
  assign oTriggerALU      = r_trig;
  assign oALUOperation    = r_op;
  assign oALUChannelA     = r_cha;
  assign oALUChannelB     = r_chb;
  assign oRAMWriteEnable  = (r_state == ST_WRITEBACK);
  assign oRAMWriteAddress = oRAMWriteEnable ? r_dest : '0;
  assign oRAMBus          = oRAMWriteEnable ? r_result : '0;
  assign oJumpFlag        = (r_state == ST_FLUSH);
  assign oJumpIp          = oJumpFlag ? r_dest : '0;
  assign oLastDestination = r_last_dest;

endmodule

// File: tb/tb_execution_dispatch_unit.sv
// Scoreboard bench: expected ALU issues, RAM writes and jumps are queued as
// stimulus is driven and retired as the DUT produces them.
module tb_execution_dispatch_unit;
  logic        Clock = 1'b0;
  logic        Reset;
  logic        iValid;
  logic        oReady;
  logic [5:0]  iOperation;
  logic [9:0]  iDestination, iSrcAddr0, iSrcAddr1;
  logic [95:0] iSource0, iSource1;
  logic        oTriggerALU;
  logic [5:0]  oALUOperation;
  logic [95:0] oALUChannelA, oALUChannelB, iALUResult, oRAMBus;
  logic        iALUOutputReady, iBranchTaken, oRAMWriteEnable, oJumpFlag, oBusy;
  logic [9:0]  oRAMWriteAddress, oJumpIp, oLastDestination;

  execution_dispatch_unit dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .iOperation(iOperation), .iDestination(iDestination),
    .iSrcAddr0(iSrcAddr0), .iSrcAddr1(iSrcAddr1),
    .iSource0(iSource0), .iSource1(iSource1),
    .oTriggerALU(oTriggerALU), .oALUOperation(oALUOperation),
    .oALUChannelA(oALUChannelA), .oALUChannelB(oALUChannelB),
    .iALUResult(iALUResult), .iALUOutputReady(iALUOutputReady),
    .iBranchTaken(iBranchTaken), .oRAMWriteEnable(oRAMWriteEnable),
    .oRAMWriteAddress(oRAMWriteAddress), .oRAMBus(oRAMBus),
    .oJumpFlag(oJumpFlag), .oJumpIp(oJumpIp),
    .oLastDestination(oLastDestination), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [5:0] op; logic [95:0] a, b, res; logic taken; } trig_t;
  typedef struct { logic [9:0] addr; logic [95:0] data; } wr_t;

  trig_t      tq[$];
  wr_t        wq[$];
  logic [9:0] jq[$];

  int   n_checks = 0;
  int   n_errors = 0;
  bit   alu_hold = 0;
  int   alu_lat  = 4;
  bit   prev_jf  = 0;
  // Reference of the last completed write, used to predict forwarding.
  bit          m_vld = 0;
  logic [9:0]  m_dest;
  logic [95:0] m_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic push(input logic [5:0] op, input logic [9:0] dest, s0a, s1a,
                      input logic [95:0] s0, s1, res, input logic taken, input bit issue);
    trig_t t;
    wr_t   w;
    bit    rdy;
    int    n;
    if (issue) begin
      t.op = op; t.res = res; t.taken = taken;
      t.a = (m_vld && s0a == m_dest) ? m_data : s0;
      t.b = (m_vld && s1a == m_dest) ? m_data : s1;
      tq.push_back(t);
      if (!op[5]) begin
        w.addr = dest; w.data = res; wq.push_back(w);
        m_vld = 1; m_dest = dest; m_data = res;
      end else if (taken) jq.push_back(dest);
    end
    iValid = 1; iOperation = op; iDestination = dest;
    iSrcAddr0 = s0a; iSrcAddr1 = s1a; iSource0 = s0; iSource1 = s1;
    n = 0;
    forever begin
      @(negedge Clock); rdy = oReady;
      @(posedge Clock); #1; n++;
      if (rdy) break;
      if (n > 200) begin chk("push_timeout", rdy, 1); break; end
    end
    iValid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((oBusy || wq.size() != 0 || tq.size() != 0) && n < 300) begin
      @(posedge Clock); #1; n++;
    end
    chk("idle_busy", oBusy, 0);
    chk("idle_pending_wr", wq.size(), 0);
  endtask

  // ALU model: checks each issue against the queued expectation and answers
  // after alu_lat cycles (or later while alu_hold is set).
  initial begin
    trig_t t;
    iALUOutputReady = 0; iALUResult = '0; iBranchTaken = 0;
    forever begin
      @(posedge Clock); #1;
      if (Reset && oTriggerALU) begin
        if (tq.size() == 0) chk("unexp_trig", oTriggerALU, 0);
        else begin
          t = tq.pop_front();
          chk("alu_op", oALUOperation, t.op);
          chk("alu_a", oALUChannelA, t.a);
          chk("alu_b", oALUChannelB, t.b);
          while (alu_hold) @(posedge Clock);
          repeat (alu_lat) @(posedge Clock);
          #1;
          iALUResult = t.res; iBranchTaken = t.taken; iALUOutputReady = 1;
          @(posedge Clock); #1;
          iALUOutputReady = 0; iBranchTaken = 0;
        end
      end
    end
  end

  // Write / jump monitor.
  initial begin
    wr_t w;
    forever begin
      @(posedge Clock); #1;
      if (oRAMWriteEnable) begin
        if (wq.size() == 0) chk("unexp_wr", oRAMWriteEnable, 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", oRAMWriteAddress, w.addr);
          chk("wr_data", oRAMBus, w.data);
        end
      end
      if (oJumpFlag) begin
        chk("jf_pulse", prev_jf, 0);
        chk("jf_ready", oReady, 0);
        if (jq.size() == 0) chk("unexp_jmp", oJumpFlag, 0);
        else chk("jmp_ip", oJumpIp, jq.pop_front());
      end
      prev_jf = oJumpFlag;
    end
  end

  initial begin
    logic [95:0] a0;
    int n;
    iValid = 0; iOperation = '0; iDestination = '0; iSrcAddr0 = '0; iSrcAddr1 = '0;
    iSource0 = '0; iSource1 = '0;
    Reset = 0;
    #3;
    chk("rst_ready", oReady, 1);
    chk("rst_busy", oBusy, 0);
    chk("rst_trig", oTriggerALU, 0);
    chk("rst_we", oRAMWriteEnable, 0);
    chk("rst_last", oLastDestination, 0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1;

    // Single add: issue latency and writeback of {3,2,1}.
    alu_lat = 4;
    push(6'h01, 10'h010, 10'h100, 10'h101, rnd96(), rnd96(),
         {32'd3, 32'd2, 32'd1}, 0, 1);
    n = 0;
    while (!oTriggerALU && n < 20) begin @(posedge Clock); #1; n++; end
    chk("issue_latency", n, 2);
    wait_idle();
    chk("last_dest_add", oLastDestination, 10'h010);

    // Fill with ALU stalled.
    alu_hold = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) a0 = rnd96();
      push(6'h02, 10'h040 + 10'(i), 10'h180 + 10'(i), 10'h1C0 + 10'(i),
           (i == 0) ? a0 : rnd96(), rnd96(), {3{32'h100 + 32'(i)}}, 0, 1);
    end
    chk("fill_ready_low", oReady, 0);
    repeat (5) @(posedge Clock);
    #1;
    chk("stall_hold_a", oALUChannelA, a0);
    chk("stall_busy", oBusy, 1);
    alu_hold = 0;
    wait_idle();

    // Forwarding on both operands.
    alu_lat = 2;
    push(6'h03, 10'h020, 10'h120, 10'h121, rnd96(), rnd96(), {3{32'd7}}, 0, 1);
    push(6'h03, 10'h030, 10'h020, 10'h122, '0, rnd96(), rnd96(), 0, 1);
    push(6'h03, 10'h031, 10'h123, 10'h030, rnd96(), rnd96(), rnd96(), 0, 1);
    wait_idle();

    // Branch not taken, then taken with two ops behind it.
    push(6'h21, 10'h03E, 10'h124, 10'h125, rnd96(), rnd96(), rnd96(), 0, 1);
    push(6'h04, 10'h050, 10'h126, 10'h127, rnd96(), rnd96(), rnd96(), 0, 1);
    wait_idle();
    alu_lat = 4;
    push(6'h21, 10'h03F, 10'h128, 10'h129, rnd96(), rnd96(), rnd96(), 1, 1);
    push(6'h04, 10'h051, 10'h12A, 10'h12B, rnd96(), rnd96(), rnd96(), 0, 0);
    push(6'h04, 10'h052, 10'h12C, 10'h12D, rnd96(), rnd96(), rnd96(), 0, 0);
    wait_idle();
    chk("br_jq_empty", jq.size(), 0);
    chk("br_ready", oReady, 1);
    chk("br_last_dest", oLastDestination, 10'h050);

    // Random mix with varying latency and occasional back-to-back forwarding.
    for (int i = 0; i < 8; i++) begin
      alu_lat = $urandom_range(1, 5);
      push(6'h05, 10'h060 + 10'(i),
           (i > 0 && $urandom_range(0, 1) == 1) ? 10'h060 + 10'(i - 1) : 10'h200 + 10'(i),
           10'h240 + 10'(i), rnd96(), rnd96(), rnd96(), 0, 1);
    end
    wait_idle();

    // Reset while waiting on the ALU with three entries queued.
    alu_hold = 1;
    push(6'h06, 10'h070, 10'h130, 10'h131, rnd96(), rnd96(), rnd96(), 0, 1);
    for (int i = 0; i < 3; i++)
      push(6'h06, 10'h071 + 10'(i), 10'h132, 10'h133, rnd96(), rnd96(), rnd96(), 0, 0);
    repeat (2) @(posedge Clock);
    #1;
    chk("pre_rst_busy", oBusy, 1);
    Reset = 0;
    tq.delete(); wq.delete(); jq.delete(); m_vld = 0;
    #1;
    chk("mid_rst_trig", oTriggerALU, 0);
    chk("mid_rst_op", oALUOperation, 0);
    chk("mid_rst_a", oALUChannelA, 0);
    chk("mid_rst_b", oALUChannelB, 0);
    chk("mid_rst_we", oRAMWriteEnable, 0);
    chk("mid_rst_wa", oRAMWriteAddress, 0);
    chk("mid_rst_bus", oRAMBus, 0);
    chk("mid_rst_jf", oJumpFlag, 0);
    chk("mid_rst_jip", oJumpIp, 0);
    chk("mid_rst_last", oLastDestination, 0);
    chk("mid_rst_busy", oBusy, 0);
    chk("mid_rst_ready", oReady, 1);
    @(negedge Clock);
    Reset = 1;
    alu_hold = 0;
    repeat (15) @(posedge Clock);
    #1;
    chk("post_rst_busy", oBusy, 0);
    chk("post_rst_last", oLastDestination, 0);

    // Forward-valid must be cleared: src address 0 matches last dest 0 but no write yet.
    alu_lat = 2;
    push(6'h07, 10'h080, 10'h000, 10'h000, rnd96(), rnd96(), rnd96(), 0, 1);
    wait_idle();
    chk("final_last_dest", oLastDestination, 10'h080);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
